// File: rtl/banco_registros_pkg.sv
// Shared types and constants for the banco_registros register bank.
package banco_registros_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] reg_word_t;

    localparam reg_idx_t ZERO_IDX = '0;

endpackage

// File: rtl/banco_registros_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on reserve, cleared on writeback.
module banco_registros_scoreboard
    import banco_registros_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_valid,
    input  logic [ADDR_W-1:0]      set_idx,
    input  logic                   clr_valid,
    input  logic [ADDR_W-1:0]      clr_idx,
    output logic [2**ADDR_W-1:0]   pending
);

    logic [2**ADDR_W-1:0] pending_q;
    logic [2**ADDR_W-1:0] pending_d;

    // Clear first so a same-index reserve overrides it (a newer producer was issued).
    always_comb begin
        pending_d = pending_q;
        if (clr_valid) begin
            pending_d[clr_idx] = 1'b0;
        end
        if (set_valid) begin
            pending_d[set_idx] = 1'b1;
        end
        if (ZERO_REG) begin
            pending_d[ADDR_W'(ZERO_IDX)] = 1'b0;
        end
    end

    // Pending-bit state register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/banco_registros_multi.sv
// Multi-port register bank: N_READ combinational read ports, one synchronous write port,
// and a pending-write scoreboard for RAW hazard detection.
// Optional macro BANCO_REGISTROS_BYPASS_EN enables write-through forwarding to read ports.
module banco_registros_multi
    import banco_registros_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned N_READ   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_READ*ADDR_W-1:0] read_register,
    output logic [N_READ*DATA_W-1:0] read_data,
    output logic [N_READ-1:0]        read_pending,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        write_register,
    input  logic [DATA_W-1:0]        write_data,
    input  logic                     reserve_valid,
    input  logic [ADDR_W-1:0]        reserve_register
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              wr_en;

    // Writes to the hardwired zero register are dropped.
    assign wr_en = reg_write && !(ZERO_REG && (write_register == ADDR_W'(ZERO_IDX)));

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[write_register] <= write_data;
        end
    end

    banco_registros_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_valid (reserve_valid),
        .set_idx   (reserve_register),
        .clr_valid (reg_write),
        .clr_idx   (write_register),
        .pending   (pending)
    );

    for (genvar k = 0; k < N_READ; k++) begin : g_read
        logic [ADDR_W-1:0] idx;
        logic              is_zero;
        logic [DATA_W-1:0] rdata;
        logic              rpend;

        assign idx     = read_register[k*ADDR_W +: ADDR_W];
        assign is_zero = ZERO_REG && (idx == ADDR_W'(ZERO_IDX));

`ifdef BANCO_REGISTROS_BYPASS_EN
        logic hit;
        assign hit = !reset && reg_write && (write_register == idx) && !is_zero;
`endif

        // Combinational read; with bypass, forward the in-flight write and hide its pending
        // bit unless the same index is being re-reserved this cycle.
        always_comb begin
            rdata = is_zero ? '0 : regs_q[idx];
            rpend = pending[idx];
`ifdef BANCO_REGISTROS_BYPASS_EN
            if (hit) begin
                rdata = write_data;
                if (!(reserve_valid && (reserve_register == idx))) begin
                    rpend = 1'b0;
                end
            end
`endif
        end

        assign read_data[k*DATA_W +: DATA_W] = rdata;
        assign read_pending[k]               = rpend;
    end

endmodule

// File: tb/tb_banco_registros_multi.sv
// Self-checking bench for banco_registros_multi (4 read ports, register 0 hardwired).
module tb_banco_registros_multi;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] read_register;
    logic [NR*DW-1:0] read_data;
    logic [NR-1:0]    read_pending;
    logic             reg_write;
    logic [AW-1:0]    write_register;
    logic [DW-1:0]    write_data;
    logic             reserve_valid;
    logic [AW-1:0]    reserve_register;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model [32];

    banco_registros_multi #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .N_READ   (NR),
        .ZERO_REG (1'b1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .read_register    (read_register),
        .read_data        (read_data),
        .read_pending     (read_pending),
        .reg_write        (reg_write),
        .write_register   (write_register),
        .write_data       (write_data),
        .reserve_valid    (reserve_valid),
        .reserve_register (reserve_register)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input int k);
        return read_data[k*DW +: DW];
    endfunction

    task automatic set_port(input int k, input logic [4:0] idx);
        read_register[k*AW +: AW] = idx;
    endtask

    // One write cycle; returns at the negedge after the write edge.
    task automatic do_write(input logic [4:0] idx, input logic [31:0] d);
        @(negedge clk);
        reg_write      = 1'b1;
        write_register = idx;
        write_data     = d;
        @(negedge clk);
        reg_write = 1'b0;
        if (idx != 5'd0) model[idx] = d;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        reset = 1'b1;
        #1;
        checks++;
        if (read_data !== '0) begin
            errors++;
            $display("FAIL reset_init_data got=%h exp=0", read_data);
        end
        checks++;
        if (read_pending !== '0) begin
            errors++;
            $display("FAIL reset_init_pending got=%b exp=0", read_pending);
        end
        @(negedge clk);
        reset = 1'b0;
        do_write(5'd5, 32'hDEADBEEF);
        set_port(0, 5'd5);
        set_port(1, 5'd6);
        @(negedge clk);
        reserve_valid    = 1'b1;
        reserve_register = 5'd6;
        @(negedge clk);
        reserve_valid = 1'b0;
        exp_q.push_back(32'hDEADBEEF);
        #1;
        got = rd(0);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL pre_reset_r5 got=%h exp=%h", got, exp);
        end
        checks++;
        if (read_pending[1] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pend_r6 got=%b exp=1", read_pending[1]);
        end
        // Mid-cycle reset, no clock edge in between.
        #1;
        reset = 1'b1;
        exp_q.push_back(32'h0);
        #1;
        got = rd(0);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL async_reset_r5 got=%h exp=%h", got, exp);
        end
        checks++;
        if (read_pending !== '0) begin
            errors++;
            $display("FAIL async_reset_pending got=%b exp=0", read_pending);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic test_write_read();
        logic [31:0] got, exp;
        do_write(5'd7, 32'h12345678);
        set_port(0, 5'd7);
        set_port(1, 5'd7);
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h12345678);
        #1;
        for (int k = 0; k < 2; k++) begin
            got = rd(k);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL r7_port%0d got=%h exp=%h", k, got, exp);
            end
        end
        do_write(5'd0, 32'hFFFFFFFF);
        set_port(0, 5'd0);
        exp_q.push_back(32'h0);
        #1;
        got = rd(0);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL r0_hardwired got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] got, exp;
        do_write(5'd3, 32'h1);
        @(negedge clk);
        reg_write      = 1'b1;
        write_register = 5'd3;
        write_data     = 32'hA5A5A5A5;
        set_port(0, 5'd3);
`ifdef BANCO_REGISTROS_BYPASS_EN
        exp_q.push_back(32'hA5A5A5A5);
`else
        exp_q.push_back(32'h1);
`endif
        #1;
        got = rd(0);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL same_cycle_r3 got=%h exp=%h", got, exp);
        end
        @(negedge clk);
        reg_write = 1'b0;
        model[3]  = 32'hA5A5A5A5;
        exp_q.push_back(32'hA5A5A5A5);
        #1;
        got = rd(0);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL next_cycle_r3 got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_scoreboard();
        set_port(0, 5'd9);
        @(negedge clk);
        reserve_valid    = 1'b1;
        reserve_register = 5'd9;
        #1;
        checks++;
        if (read_pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL r9_pend_before_edge got=%b exp=0", read_pending[0]);
        end
        @(negedge clk);
        reserve_valid = 1'b0;
        #1;
        checks++;
        if (read_pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL r9_pend_set got=%b exp=1", read_pending[0]);
        end
        @(negedge clk);
        reg_write      = 1'b1;
        write_register = 5'd9;
        write_data     = 32'h99;
        #1;
`ifdef BANCO_REGISTROS_BYPASS_EN
        checks++;
        if (read_pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL r9_pend_write_cycle got=%b exp=0", read_pending[0]);
        end
`else
        checks++;
        if (read_pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL r9_pend_write_cycle got=%b exp=1", read_pending[0]);
        end
`endif
        @(negedge clk);
        reg_write = 1'b0;
        model[9]  = 32'h99;
        #1;
        checks++;
        if (read_pending[0] !== 1'b0) begin
            errors++;
            $display("FAIL r9_pend_cleared got=%b exp=0", read_pending[0]);
        end
        // Reserve and write the same index: reserve wins.
        set_port(1, 5'd4);
        @(negedge clk);
        reserve_valid    = 1'b1;
        reserve_register = 5'd4;
        reg_write        = 1'b1;
        write_register   = 5'd4;
        write_data       = 32'h44;
        @(negedge clk);
        reserve_valid = 1'b0;
        reg_write     = 1'b0;
        model[4]      = 32'h44;
        #1;
        checks++;
        if (read_pending[1] !== 1'b1) begin
            errors++;
            $display("FAIL r4_reserve_wins got=%b exp=1", read_pending[1]);
        end
        // Reserving r0 never sets; reserve twice then one write clears a single-bit entry.
        set_port(2, 5'd0);
        set_port(3, 5'd10);
        @(negedge clk);
        reserve_valid    = 1'b1;
        reserve_register = 5'd0;
        @(negedge clk);
        reserve_register = 5'd10;
        @(negedge clk);
        reserve_register = 5'd10;
        @(negedge clk);
        reserve_valid = 1'b0;
        #1;
        checks++;
        if (read_pending[2] !== 1'b0) begin
            errors++;
            $display("FAIL r0_never_pending got=%b exp=0", read_pending[2]);
        end
        checks++;
        if (read_pending[3] !== 1'b1) begin
            errors++;
            $display("FAIL r10_double_reserve got=%b exp=1", read_pending[3]);
        end
        do_write(5'd10, 32'hA0A0);
        #1;
        checks++;
        if (read_pending[3] !== 1'b0) begin
            errors++;
            $display("FAIL r10_single_clear got=%b exp=0", read_pending[3]);
        end
        // Reserve r11 while writing non-pending r12: both effects land.
        set_port(2, 5'd11);
        set_port(3, 5'd12);
        @(negedge clk);
        reserve_valid    = 1'b1;
        reserve_register = 5'd11;
        reg_write        = 1'b1;
        write_register   = 5'd12;
        write_data       = 32'hC12;
        @(negedge clk);
        reserve_valid = 1'b0;
        reg_write     = 1'b0;
        model[12]     = 32'hC12;
        #1;
        checks++;
        if (read_pending[3:2] !== 2'b01) begin
            errors++;
            $display("FAIL r11_r12_pending got=%b exp=01", read_pending[3:2]);
        end
        do_write(5'd4, 32'h4444);
        #1;
        checks++;
        if (read_pending[1] !== 1'b0) begin
            errors++;
            $display("FAIL r4_cleared got=%b exp=0", read_pending[1]);
        end
    endtask

    task automatic test_multi_port();
        logic [31:0] got, exp;
        logic [4:0]  idx [4];
        idx[0] = 5'd1;
        idx[1] = 5'd2;
        idx[2] = 5'd1;
        idx[3] = 5'd31;
        do_write(5'd1, 32'h11111111);
        do_write(5'd2, 32'h22222222);
        do_write(5'd31, 32'hF0F0F0F0);
        for (int k = 0; k < 4; k++) begin
            set_port(k, idx[k]);
            exp_q.push_back(model[idx[k]]);
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            got = rd(k);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL multi_port%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        logic [4:0]  widx;
        logic [31:0] wdat;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i > 0 && widx != 5'd0) model[widx] = wdat;
            widx           = 5'($urandom_range(0, 31));
            wdat           = $urandom;
            reg_write      = 1'b1;
            write_register = widx;
            write_data     = wdat;
        end
        @(negedge clk);
        reg_write = 1'b0;
        if (widx != 5'd0) model[widx] = wdat;
        for (int b = 0; b < 32; b += 4) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                set_port(k, 5'(b + k));
                exp_q.push_back(model[b + k]);
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                got = rd(k);
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL b2b_r%0d got=%h exp=%h", b + k, got, exp);
                end
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        read_register    = '0;
        reg_write        = 1'b0;
        write_register   = '0;
        write_data       = '0;
        reserve_valid    = 1'b0;
        reserve_register = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_scoreboard();
        test_multi_port();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
